// File: rtl/periph_burst_scheduler_pkg.sv
// Shared types and constants for the peripheral-to-USB burst scheduler.
// Also provides the width and circular-index helpers used by every scheduler file.
package periph_burst_scheduler_pkg;

    localparam int NUM_PERIPHERALS  = 8;
    localparam int USB_PACKET_WIDTH = 32;
    localparam int SCHED_MAX_BURST  = 16;

    typedef enum logic [1:0] {SCH_IDLE, SCH_BURST, SCH_SWITCH} sched_state_t;

    // Index width that stays legal (>=1 bit) even for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (base + inc) mod n for base, inc < n; avoids relying on power-of-2 wrap
    function automatic int wrap_add(input int base, input int inc, input int n);
        int s;
        s = base + inc;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/periph_burst_scheduler_if.sv
// Bundle of rx-FIFO side and downstream-FIFO side signals of the burst scheduler.
// The master modport is the scheduler; the slave modport is the FIFO environment.
interface periph_burst_scheduler_if #(
    parameter int N_REQ  = periph_burst_scheduler_pkg::NUM_PERIPHERALS,
    parameter int DATA_W = periph_burst_scheduler_pkg::USB_PACKET_WIDTH
);
    import periph_burst_scheduler_pkg::*;

    localparam int GW = idx_width(N_REQ);

    logic [N_REQ-1:0]        rx_empty;
    logic [N_REQ-1:0]        rx_almost_full;
    logic [N_REQ*DATA_W-1:0] rx_data;
    logic [N_REQ-1:0]        rx_read;
    logic                    out_afull;
    logic [DATA_W-1:0]       out_data;
    logic                    out_wr;
    logic [GW-1:0]           grant;
    logic                    grant_valid;

    modport master (
        input  rx_empty, rx_almost_full, rx_data, out_afull,
        output rx_read, out_data, out_wr, grant, grant_valid
    );

    modport slave (
        output rx_empty, rx_almost_full, rx_data, out_afull,
        input  rx_read, out_data, out_wr, grant, grant_valid
    );

endinterface

// File: rtl/periph_burst_scheduler_rr_pick.sv
// Circular find-first: rotates the request vector so 'start' sits at bit 0,
// finds the lowest set bit, and maps the offset back to an absolute index.
module periph_burst_scheduler_rr_pick
    import periph_burst_scheduler_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] rotated;
    logic [W-1:0] offset;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign rotated[gi] = vec[W'(wrap_add(int'(start), gi, N))];
        end
    endgenerate

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = W'(k);
            end
        end
        idx = W'(wrap_add(int'(start), int'(offset), N));
    end

endmodule

// File: rtl/periph_burst_scheduler.sv
// Round-robin burst arbiter sharing the USB-bound FIFO write port among the peripheral
// rx FIFOs, with urgency priority for nearly-full FIFOs and a registered write stage.
module periph_burst_scheduler
    import periph_burst_scheduler_pkg::*;
#(
    parameter int N_REQ     = NUM_PERIPHERALS,
    parameter int DATA_W    = USB_PACKET_WIDTH,
    parameter int MAX_BURST = SCHED_MAX_BURST
) (
    input logic                   clk,
    input logic                   rst,
    periph_burst_scheduler_if.master bus
);

    localparam int GW = idx_width(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    sched_state_t      state_reg;
    logic [GW-1:0]     grant_reg;
    logic [GW-1:0]     rr_ptr_reg;
    logic [CW-1:0]     burst_cnt_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_wr_reg;
    logic              grant_valid_reg;

    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  urg;
    logic              urg_found;
    logic              req_found;
    logic [GW-1:0]     urg_idx;
    logic [GW-1:0]     req_idx;
    logic [GW-1:0]     pick_idx;
    logic [GW-1:0]     next_ptr;
    logic [DATA_W-1:0] rx_words [N_REQ];
    logic [DATA_W-1:0] sel_data;
    logic              pop;
    logic              burst_done;

    assign req = ~bus.rx_empty;
    assign urg = req & bus.rx_almost_full;

    periph_burst_scheduler_rr_pick #(.N(N_REQ), .W(GW)) u_pick_urg (
        .vec   (urg),
        .start (rr_ptr_reg),
        .found (urg_found),
        .idx   (urg_idx)
    );

    periph_burst_scheduler_rr_pick #(.N(N_REQ), .W(GW)) u_pick_req (
        .vec   (req),
        .start (rr_ptr_reg),
        .found (req_found),
        .idx   (req_idx)
    );

    assign pick_idx = urg_found ? urg_idx : req_idx;
    assign next_ptr = GW'(wrap_add(int'(grant_reg), 1, N_REQ));

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign rx_words[gi]    = bus.rx_data[gi*DATA_W +: DATA_W];
            assign bus.rx_read[gi] = pop && (grant_reg == GW'(gi));
        end
    endgenerate

    assign sel_data = rx_words[grant_reg];

    // Pop only when the owner has data and the downstream can absorb the word in flight
    assign pop        = (state_reg == SCH_BURST) && req[grant_reg] && !bus.out_afull;
    assign burst_done = (pop && (burst_cnt_reg == LAST_CNT)) || bus.rx_empty[grant_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= SCH_IDLE;
            grant_reg       <= '0;
            rr_ptr_reg      <= '0;
            burst_cnt_reg   <= '0;
            out_data_reg    <= '0;
            out_wr_reg      <= 1'b0;
            grant_valid_reg <= 1'b0;
        end else begin
            out_wr_reg <= pop;
            if (pop) begin
                out_data_reg <= sel_data;
            end

            case (state_reg)
                SCH_IDLE: begin
                    if (req_found) begin
                        grant_reg       <= pick_idx;
                        burst_cnt_reg   <= '0;
                        grant_valid_reg <= 1'b1;
                        state_reg       <= SCH_BURST;
                    end
                end
                SCH_BURST: begin
                    if (pop) begin
                        burst_cnt_reg <= burst_cnt_reg + 1'b1;
                    end
                    if (burst_done) begin
                        rr_ptr_reg      <= next_ptr;
                        grant_valid_reg <= 1'b0;
                        state_reg       <= SCH_SWITCH;
                    end
                end
                SCH_SWITCH: begin
                    // Dead cycle lets the last pop reach the empty flags before re-arbitration
                    state_reg <= SCH_IDLE;
                end
                default: begin
                    state_reg <= SCH_IDLE;
                end
            endcase
        end
    end

    assign bus.out_data    = out_data_reg;
    assign bus.out_wr      = out_wr_reg;
    assign bus.grant       = grant_reg;
    assign bus.grant_valid = grant_valid_reg;

endmodule

// File: tb/tb_periph_burst_scheduler.sv
// Bench for periph_burst_scheduler: FWFT source FIFO models, a downstream occupancy model,
// a per-requester in-order scoreboard, a pick-rule vector table and burst-level sequences.
module tb_periph_burst_scheduler;
    import periph_burst_scheduler_pkg::*;

    localparam int N      = 8;
    localparam int DW     = 32;
    localparam int MB     = 16;
    localparam int MEMD   = 64;
    localparam int DDEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    periph_burst_scheduler_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    periph_burst_scheduler #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] nonempty;
        logic [7:0] af;
        logic       stall;
        int         exp_grant;
    } vec_t;

    vec_t vecs [8];

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [N][MEMD];
    int head [N];
    int tail [N];
    int gen_seq [N];
    int exp_seq [N];
    int ds_cnt = 0;
    int drain_pct = 100;
    bit rand_mode = 0;
    bit verbose = 1;
    logic [7:0] af_mask = '0;
    logic afull_force = 1'b0;

    logic [N-1:0] s_rd;
    logic         s_wr;
    logic [31:0]  s_data;
    logic         s_gv;
    logic [2:0]   s_g;
    bit           prev_rd_any = 0;
    logic [31:0]  prev_pop_word = '0;

    int log_g [64];
    int log_len [64];
    int log_dur [64];
    int log_gap [64];
    int n_log = 0;
    bit prev_gv = 0;
    int cur_len = 0;
    int cur_dur = 0;
    int gap = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input int i);
        mem[i][tail[i] % MEMD] = {8'(i), 24'(gen_seq[i])};
        gen_seq[i]++;
        tail[i]++;
    endtask

    task automatic push_n(input int i, input int n);
        for (int k = 0; k < n; k++) push_word(i);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (tail[i] != head[i]) return 0;
        return 1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            int c;
            c = tail[i] - head[i];
            bus.rx_empty[i]           = (c == 0);
            bus.rx_almost_full[i]     = af_mask[i] | (rand_mode && c >= 6);
            bus.rx_data[i*DW +: DW]   = (c > 0) ? mem[i][head[i] % MEMD] : '0;
        end
        bus.out_afull = afull_force | ((DDEPTH - ds_cnt) <= 1);
    endtask

    // One clock: sample outputs at the falling edge, update models just after the rising edge
    task automatic step();
        @(negedge clk);
        s_rd   = bus.rx_read;
        s_wr   = bus.out_wr;
        s_data = bus.out_data;
        s_gv   = bus.grant_valid;
        s_g    = bus.grant;
        check("rd_onehot", 64'($onehot0(s_rd)), 64'd1);
        check("rd_from_empty", 64'(s_rd & bus.rx_empty), 64'd0);
        check("wr_latency", 64'(s_wr), 64'(prev_rd_any));
        if (s_wr && prev_rd_any) check("wr_data", 64'(s_data), 64'(prev_pop_word));

        if (s_gv && !prev_gv) begin
            if (n_log > 0) log_gap[n_log] = gap;
            log_g[n_log] = int'(s_g);
            cur_len = 0;
            cur_dur = 0;
        end
        if (s_gv) begin
            cur_len += $countones(s_rd);
            cur_dur++;
        end
        if (!s_gv && prev_gv) begin
            log_len[n_log] = cur_len;
            log_dur[n_log] = cur_dur;
            if (verbose) $display("burst %0d: grant=%0d words=%0d cycles=%0d", n_log, log_g[n_log], cur_len, cur_dur);
            if (n_log < 63) n_log++;
            gap = 0;
        end
        if (!s_gv) gap++;
        prev_gv = s_gv;

        @(posedge clk);
        #1;
        if (s_wr) begin
            int idx;
            check("ds_overflow", 64'(ds_cnt < DDEPTH), 64'd1);
            ds_cnt++;
            idx = int'(s_data[31:24]);
            if (idx < N) begin
                check("order", 64'(s_data[23:0]), 64'(exp_seq[idx][23:0]));
                exp_seq[idx] = int'(s_data[23:0]) + 1;
            end else begin
                check("word_tag", 64'(idx), 64'(N - 1));
            end
        end
        prev_rd_any = |s_rd;
        for (int i = 0; i < N; i++) begin
            if (s_rd[i] && (tail[i] != head[i])) begin
                prev_pop_word = mem[i][head[i] % MEMD];
                head[i]++;
            end
        end
        if (ds_cnt > 0 && $urandom_range(99) < drain_pct) ds_cnt--;
        if (rand_mode) begin
            for (int i = 0; i < N; i++)
                if ((tail[i] - head[i]) < 12 && $urandom_range(99) < 15) push_word(i);
            afull_force = ($urandom_range(99) < 5);
        end
        drive();
    endtask

    task automatic run_until_idle(input int maxc);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3) begin
            step();
            n++;
            if (all_empty() && !s_gv && ds_cnt == 0) quiet++;
            else quiet = 0;
            if (n > maxc) begin
                checks++;
                errors++;
                $display("FAIL timeout: still busy after %0d cycles, required idle", n);
                break;
            end
        end
    endtask

    task automatic do_reset(input bit first);
        rst = 1'b1;
        #1;
        check("rst_out_wr", 64'(bus.out_wr), 64'd0);
        check("rst_rx_read", 64'(bus.rx_read), 64'd0);
        check("rst_grant_valid", 64'(bus.grant_valid), 64'd0);
        check("rst_grant", 64'(bus.grant), 64'd0);
        if (first) check("rst_out_data", 64'(bus.out_data), 64'd0);
        for (int i = 0; i < N; i++) begin
            head[i] = tail[i];
            exp_seq[i] = gen_seq[i];
        end
        ds_cnt = 0;
        prev_rd_any = 0;
        af_mask = '0;
        afull_force = 1'b0;
        n_log = 0;
        prev_gv = 0;
        gap = 0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        int eg [6];
        int el [6];
        int n;
        logic [7:0] exp_rd;

        vecs[0] = '{8'h28, 8'h00, 1'b0, 3};
        vecs[1] = '{8'hA0, 8'h80, 1'b0, 7};
        vecs[2] = '{8'hFF, 8'h0C, 1'b0, 2};
        vecs[3] = '{8'h01, 8'h00, 1'b0, 0};
        vecs[4] = '{8'h90, 8'h10, 1'b0, 4};
        vecs[5] = '{8'h42, 8'h40, 1'b1, 6};
        vecs[6] = '{8'h81, 8'h00, 1'b0, 0};
        vecs[7] = '{8'h06, 8'h01, 1'b0, 1};
        eg = '{0, 5, 0, 5, 0, 5};
        el = '{16, 16, 16, 16, 8, 8};

        for (int i = 0; i < N; i++) begin
            head[i] = 0; tail[i] = 0; gen_seq[i] = 0; exp_seq[i] = 0;
        end
        drive();
        #2;
        do_reset(1);

        // Pick rule from a fresh pointer of 0
        for (int v = 0; v < 8; v++) begin
            do_reset(0);
            for (int i = 0; i < N; i++) if (vecs[v].nonempty[i]) push_n(i, 2);
            af_mask = vecs[v].af;
            afull_force = vecs[v].stall;
            drive();
            step();
            step();
            exp_rd = vecs[v].stall ? 8'h00 : (8'h01 << vecs[v].exp_grant);
            check($sformatf("vec%0d_grant", v), 64'(s_g), 64'(vecs[v].exp_grant));
            check($sformatf("vec%0d_grant_valid", v), 64'(s_gv), 64'd1);
            check($sformatf("vec%0d_rx_read", v), 64'(s_rd), 64'(exp_rd));
        end

        // Single requester 3 with 5 words, then the pointer sits at 4
        do_reset(0);
        push_n(3, 5);
        drive();
        run_until_idle(100);
        check("t1_bursts", 64'(n_log), 64'd1);
        check("t1_grant", 64'(log_g[0]), 64'd3);
        check("t1_len", 64'(log_len[0]), 64'd5);
        check("t1_dur", 64'(log_dur[0]), 64'd6);
        push_n(2, 1);
        push_n(5, 1);
        drive();
        run_until_idle(100);
        check("t1_ptr4_grant", 64'(log_g[1]), 64'd5);
        check("t1_next_grant", 64'(log_g[2]), 64'd2);

        // Two heavy requesters alternate in MAX_BURST chunks
        do_reset(0);
        push_n(0, 40);
        push_n(5, 40);
        drive();
        run_until_idle(400);
        check("t2_bursts", 64'(n_log), 64'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t2_grant%0d", k), 64'(log_g[k]), 64'(eg[k]));
            check($sformatf("t2_len%0d", k), 64'(log_len[k]), 64'(el[k]));
            if (k > 0) check($sformatf("t2_gap%0d", k), 64'(log_gap[k]), 64'd2);
        end
        check("t2_all0", 64'(exp_seq[0]), 64'(gen_seq[0]));
        check("t2_all5", 64'(exp_seq[5]), 64'(gen_seq[5]));

        // Urgency beats the pointer, then the pointer wraps from 7 to 1
        do_reset(0);
        push_n(0, 1);
        drive();
        run_until_idle(100);
        n_log = 0;
        for (int i = 1; i <= 6; i++) push_n(i, 1);
        af_mask = 8'h40;
        drive();
        run_until_idle(200);
        check("t3_bursts", 64'(n_log), 64'd6);
        check("t3_urgent_first", 64'(log_g[0]), 64'd6);
        check("t3_wrap_next", 64'(log_g[1]), 64'd1);
        af_mask = '0;

        // Downstream stall mid-burst
        do_reset(0);
        push_n(2, 40);
        drive();
        n = 0;
        while (cur_len < 3 && n < 50) begin
            step();
            n++;
        end
        check("t4_reach_pop3", 64'(n < 50), 64'd1);
        afull_force = 1'b1;
        drive();
        for (int s = 0; s < 4; s++) begin
            step();
            check($sformatf("t4_stall_rd%0d", s), 64'(s_rd), 64'd0);
            if (s > 0) check($sformatf("t4_stall_wr%0d", s), 64'(s_wr), 64'd0);
        end
        afull_force = 1'b0;
        drive();
        run_until_idle(400);
        check("t4_bursts", 64'(n_log), 64'd3);
        check("t4_len0", 64'(log_len[0]), 64'd16);
        check("t4_len1", 64'(log_len[1]), 64'd16);
        check("t4_len2", 64'(log_len[2]), 64'd8);
        check("t4_all", 64'(exp_seq[2]), 64'(gen_seq[2]));

        // Reset mid-burst with a word in the output register
        do_reset(0);
        push_n(4, 2);
        drive();
        run_until_idle(100);
        push_n(4, 10);
        drive();
        n = 0;
        while (s_rd == '0 && n < 50) begin
            step();
            n++;
        end
        check("t5_reach_pop", 64'(n < 50), 64'd1);
        check("t5_wr_pending", 64'(bus.out_wr), 64'd1);
        do_reset(0);
        step();
        check("t5_idle_gv", 64'(s_gv), 64'd0);
        check("t5_idle_grant", 64'(s_g), 64'd0);
        check("t5_no_wr", 64'(s_wr), 64'd0);
        push_n(1, 1);
        push_n(7, 1);
        drive();
        run_until_idle(100);
        check("t5_ptr0_grant", 64'(log_g[0]), 64'd1);
        check("t5_next_grant", 64'(log_g[1]), 64'd7);

        // Random traffic with backpressure
        do_reset(0);
        verbose = 0;
        rand_mode = 1;
        drain_pct = 50;
        for (int c = 0; c < 10000; c++) step();
        rand_mode = 0;
        afull_force = 1'b0;
        drain_pct = 100;
        drive();
        run_until_idle(5000);
        for (int i = 0; i < N; i++)
            check($sformatf("t6_delivered%0d", i), 64'(exp_seq[i]), 64'(gen_seq[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
